// File: rtl/uart_tx_sched.sv
// uart_tx_sched: schedules two requesters onto a byte-wide UART transmitter
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_a, data_a[15:0] requester A, sent as two bytes, low byte first
//   req_b, data_b[7:0]  requester B, sent as one byte
//   tx_busy             transmitter busy flag
//   P_DATA, Data_Valid  byte and one-cycle valid pulse to the transmitter
//   ack_a, ack_b        one-cycle grant acknowledges
//   sched_busy          high whenever the scheduler is not idle
//   err_timeout         sticky: transmitter never went busy after a byte
// Build option: define TX_SCHED_RR_EN for round-robin arbitration; otherwise A has fixed priority.
module uart_tx_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic [15:0] data_a,
    input  logic        req_b,
    input  logic [7:0]  data_b,
    input  logic        tx_busy,
    output logic [7:0]  P_DATA,
    output logic        Data_Valid,
    output logic        ack_a,
    output logic        ack_b,
    output logic        sched_busy,
    output logic        err_timeout
);
    typedef enum logic [1:0] {IDLE, SEND, ACCEPT, DRAIN} state_t;
    state_t state, state_n;
    logic [1:0] cnt, tcnt;
    logic [7:0] hi_byte;
    logic grant, next_byte, pick_a;
`ifdef TX_SCHED_RR_EN
    // last_b set means B was granted last, so A wins the next contention
    logic last_b;
    always_comb pick_a = req_a && (!req_b || last_b);
    always_ff @(posedge clk)
        if (rst)
            last_b <= 1'b1;
        else if (grant)
            last_b <= !pick_a;
`else
    always_comb pick_a = req_a;
`endif
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = (!tx_busy && (req_a || req_b)) ? SEND : IDLE;
            SEND:    state_n = ACCEPT;
            ACCEPT:  state_n = tx_busy ? DRAIN : (tcnt == 2'd3 ? IDLE : ACCEPT);
            DRAIN:   state_n = tx_busy ? DRAIN : (cnt != 2'd0 ? SEND : IDLE);
            default: state_n = IDLE;
        endcase
    end
    always_comb grant = state == IDLE && state_n == SEND;
    always_comb next_byte = state == DRAIN && state_n == SEND;
    always_ff @(posedge clk) begin
        if (rst) begin
            P_DATA      <= '0;
            Data_Valid  <= 1'b0;
            ack_a       <= 1'b0;
            ack_b       <= 1'b0;
            sched_busy  <= 1'b0;
            err_timeout <= 1'b0;
            cnt         <= '0;
            tcnt        <= '0;
            hi_byte     <= '0;
        end else begin
            Data_Valid <= grant || next_byte;
            ack_a      <= grant && pick_a;
            ack_b      <= grant && !pick_a;
            sched_busy <= state_n != IDLE;
            if (grant) begin
                P_DATA  <= pick_a ? data_a[7:0] : data_b;
                hi_byte <= data_a[15:8];
                cnt     <= pick_a ? 2'd2 : 2'd1;
            end
            // only A has a second byte, so the next byte is always the captured high byte
            if (next_byte)
                P_DATA <= hi_byte;
            if (state == SEND) begin
                cnt  <= cnt - 2'd1;
                tcnt <= '0;
            end
            // fourth idle ACCEPT cycle: give up and drop whatever is left
            if (state == ACCEPT && !tx_busy) begin
                tcnt <= tcnt + 2'd1;
                if (tcnt == 2'd3) begin
                    err_timeout <= 1'b1;
                    cnt         <= '0;
                end
            end
        end
    end
endmodule
